loop_count_ctrl: RTL and testbench

Synthesizable bounded loop controller: on a `start` pulse it latches an iteration limit and produces the count sequence 1..limit as a valid/ready stream, one value per accepted transfer. When the limit is reached it pulses `done` with the final count. It sits directly upstream of a stream consumer (monitor/display or datapath stage) that takes one count per iteration and may apply backpressure.

---
 rtl/loop_pkg.sv | 13 +
 rtl/loop_count_ctrl.sv | 112 +++++++++++
 tb/tb_loop_count_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/loop_pkg.sv
// Shared definitions for the bounded loop controller: FSM state encoding
// and the default counter width.
package loop_pkg;

    localparam int LOOP_CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        LOOP_IDLE = 2'd0,
        LOOP_RUN  = 2'd1,
        LOOP_DONE = 2'd2
    } loop_state_e;

endpackage

// File: rtl/loop_count_ctrl.sv
// Bounded loop controller: streams counts 1..limit over valid/ready, then pulses done.
// Optional early termination via the abort port when LOOP_CNT_ABORT_EN is defined.
module loop_count_ctrl
    import loop_pkg::*;
#(
    parameter int CNT_W = LOOP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
`ifdef LOOP_CNT_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             done,
    output logic [CNT_W-1:0] final_count
);

    loop_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_limit;
    logic             r_busy;
    logic             r_valid;
    logic [CNT_W-1:0] r_out_count;
    logic             r_done;
    logic [CNT_W-1:0] r_final;

    logic             w_abort;
    logic             w_xfer;
    logic [CNT_W-1:0] w_next;

`ifdef LOOP_CNT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_xfer = r_valid & out_ready;
    assign w_next = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOOP_IDLE;
            r_cnt       <= '0;
            r_limit     <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_out_count <= '0;
            r_done      <= 1'b0;
            r_final     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOOP_IDLE: begin
                    if (start) begin
                        r_limit <= limit;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (limit == '0) begin
                            r_state <= LOOP_DONE;
                            r_done  <= 1'b1;
                            r_final <= '0;
                        end else begin
                            r_state     <= LOOP_RUN;
                            r_valid     <= 1'b1;
                            r_out_count <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                LOOP_RUN: begin
                    // A transfer coinciding with abort is counted before terminating.
                    if (w_xfer) begin
                        r_cnt <= w_next;
                        if ((w_next == r_limit) || w_abort) begin
                            r_state <= LOOP_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_final <= w_next;
                        end else begin
                            r_out_count <= w_next + 1'b1;
                        end
                    end else if (w_abort) begin
                        r_state <= LOOP_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_final <= r_cnt;
                    end
                end
                LOOP_DONE: begin
                    r_state <= LOOP_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= LOOP_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign out_valid   = r_valid;
    assign out_count   = r_out_count;
    assign done        = r_done;
    assign final_count = r_final;

endmodule

// File: tb/tb_loop_count_ctrl.sv
// Scoreboard bench for loop_count_ctrl: stimulus queues expected counts and
// final counts; a negedge monitor pops and compares on every transfer and done.
module tb_loop_count_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] limit;
    logic         abort;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_count;
    logic         done;
    logic [W-1:0] final_count;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_cnt[$];
    int exp_done[$];

    bit           stalled;
    logic [W-1:0] held_count;

    loop_count_ctrl #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .limit       (limit),
`ifdef LOOP_CNT_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .done        (done),
        .final_count (final_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted transfer and every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_count_held", int'(out_count), int'(held_count));
            end
            if (out_valid && out_ready) begin
                if (exp_cnt.size() == 0) check("unexpected_transfer", int'(out_count), -1);
                else check("xfer_count", int'(out_count), exp_cnt.pop_front());
            end
            if (done) begin
                check("done_valid_low", int'(out_valid), 0);
                if (exp_done.size() == 0) check("unexpected_done", int'(final_count), -1);
                else check("final_count", int'(final_count), exp_done.pop_front());
            end
            stalled    = out_valid && !out_ready;
            held_count = out_count;
        end
    end

    // Runs one loop. Expected edge count from start-sample to done is given by the caller.
    task automatic run_loop(input int lim, input int n_exp, input bit toggle,
                            input int exp_edges, input int abort_at, input string tag);
        int cycles;
        for (int i = 1; i <= n_exp; i++) exp_cnt.push_back(i);
        exp_done.push_back(n_exp);
        @(posedge clk); #1;
        start = 1'b1;
        limit = W'(lim);
        @(posedge clk); #1;
        start = 1'b0;
        limit = W'(lim ^ 5);
        check({tag, "_busy_after_start"}, int'(busy), 1);
        check({tag, "_valid_after_start"}, int'(out_valid), (lim != 0) ? 1 : 0);
        cycles = 0;
        while (!done && cycles < 200) begin
            out_ready = toggle ? ((cycles % 2) == 0) : 1'b1;
            start     = !toggle && (lim == 15) && (cycles == 3 || cycles == 7);
            abort     = (cycles == abort_at);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, "_done_latency"}, cycles, exp_edges);
        check({tag, "_valid_at_done"}, int'(out_valid), 0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_cnt_queue_empty"}, exp_cnt.size(), 0);
        check({tag, "_done_queue_empty"}, exp_done.size(), 0);
    endtask

    initial begin
        int cycles;
        rst_n     = 1'b0;
        start     = 1'b0;
        limit     = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(out_count), 0);
        check("rst_final", int'(final_count), 0);
        #5 rst_n = 1'b1;

        run_loop(10, 10, 1'b0, 10, -1, "lim10");
        run_loop(5, 5, 1'b1, 9, -1, "lim5_bp");
        run_loop(0, 0, 1'b0, 0, -1, "lim0");
        run_loop(15, 15, 1'b0, 15, -1, "lim15");

        // Asynchronous reset after three transfers of an 8-iteration loop
        @(posedge clk); #1;
        start = 1'b1;
        limit = 4'd8;
        for (int i = 1; i <= 3; i++) exp_cnt.push_back(i);
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        repeat (3) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("pre_rst_count", int'(out_count), 4);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_count", int'(out_count), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_final", int'(final_count), 0);
        check("midrst_xfers_seen", exp_cnt.size(), 0);
        exp_cnt.delete();
        exp_done.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_loop(2, 2, 1'b0, 2, -1, "after_rst");

`ifdef LOOP_CNT_ABORT_EN
        run_loop(10, 4, 1'b0, 4, 3, "abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
